sl_rx_fifo: RTL and testbench
=============================

Name: sl_rx_fifo

Overview:
- Parametrised next-generation serial-line (SL) receiver for the two-wire return-to-idle line.
- Line protocol: both wires idle high. A bit is a low pulse on one wire: low on sl1 = '1', low on sl0 = '0'. Both wires low together = stop.
- Adds over the previous receiver: generic word width up to DATA_W, configurable bit strobe, inter-bit timeout, overlength detection and a receive FIFO with a valid/ready output, so words are not lost while software is slow.
- Sits between the SL pins and the APB register block; the register block drives the cfg_* inputs and pops the FIFO.

Parameters:
- DATA_W, 32: maximum data bits per word (1..32).
- FIFO_DEPTH, 4: receive FIFO entries; must be a power of 2, at least 2.
- STROBE_POS, 8: clk cycles from the detected falling edge to the sample point (at least 2).
- TIMEOUT, 64: maximum cycles allowed in GAP or RELEASE before abort (greater than STROBE_POS).
- SYNC_STAGES, 2: input synchroniser depth (at least 2).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset; synchronous, active-low.
- sl0_i  in  1  zeroes line, asynchronous, idle high.
- sl1_i  in  1  ones line, asynchronous, idle high.
- cfg_en  in  1  receiver enable.
- cfg_len  in  6  data bits per word; 0 or any value above DATA_W means DATA_W.
- cfg_parity_en  in  1  parity bit follows the data bits.
- m_valid  out  1  FIFO not empty.
- m_ready  in  1  consumer accepts the head entry.
- m_data  out  DATA_W  head word, right-aligned, unused upper bits 0.
- m_perr  out  1  parity error flag of the head word.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- busy  out  1  a word is in progress (state is not IDLE).
- err_len  out  1  one-cycle pulse: wrong bit count, or inter-bit timeout.
- err_level  out  1  one-cycle pulse: glitch at the strobe, or a line stuck low.
- ovf  out  1  sticky flag: a completed word was dropped because the FIFO was full.
- ovf_clr  in  1  clears ovf.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE; all counters, the shift register, FIFO pointers and FIFO storage go to 0.
  - All outputs go to 0.
  - Synchroniser flops go to 1.
- Inputs: sl0_i and sl1_i pass through SYNC_STAGES flops. All further references mean the synchronised lines s0 and s1.
- Word start (IDLE, cfg_en=1, s0 or s1 low):
  - Latch cfg_len (after mapping) and cfg_parity_en for the whole word.
  - Set cnt=0 and go to STROBE.
- STROBE: cnt increments every cycle. When cnt==STROBE_POS-1, sample (s0,s1):
  - (1,1): pulse err_level, drop the word, go to IDLE.
  - Exactly one line low, with bit_cnt < len+par: this is a bit. Data bits fill from bit 0 upward (LSB first). The parity bit is stored separately. Increment bit_cnt, go to RELEASE.
  - Exactly one line low, with bit_cnt == len+par: overlength. Pulse err_len, drop the word, go to DRAIN.
  - (0,0) stop: go to DRAIN. If bit_cnt == len+par, complete the word. Otherwise pulse err_len and drop it.
- RELEASE: go to GAP with cnt=0 once s0=s1=1. If cnt reaches TIMEOUT first, pulse err_level, drop the word, go to DRAIN.
- GAP:
  - If either line goes low: cnt=0, go to STROBE.
  - If cnt reaches TIMEOUT first: pulse err_len, drop the word, go to IDLE.
- DRAIN: go to IDLE once s0=s1=1.
- Parity: odd. perr=1 when (ones in data + parity bit) is even. With cfg_parity_en=0, perr=0.
- Completion: the word is pushed on the cycle after the stop sample; m_valid is high on the following cycle if the FIFO was empty.
- FIFO:
  - First-word-fall-through: m_data and m_perr always show the head entry.
  - Pop when m_valid && m_ready.
  - Push and pop in the same cycle: fifo_level unchanged.
  - Push while full with no pop: the word is dropped and ovf is set.
  - Push while full with a simultaneous pop: accepted.
  - ovf_clr and a new overflow in the same cycle: ovf stays 1.
  - Pointers wrap modulo FIFO_DEPTH.
- cfg_en=0: state is forced to IDLE at the next edge and any partial word is discarded without an error pulse. FIFO contents and ovf are kept, and popping still works.
- Reset mid-word: the partial word is lost, the FIFO is emptied and no error pulses are produced.

Test Plan:
- Basic word: cfg_len=8, parity off. Send 0xA5 LSB first (pulses 20 cycles low, 20 high), then stop. Expect m_valid 1, m_data=0x000000A5, m_perr=0, fifo_level=1, no error pulses.
- Parity: cfg_len=8, parity on. Send 0x03 with parity bit 1 -> m_perr=0. Repeat with parity bit 0 -> m_perr=1. The data is pushed in both cases.
- Length errors:
  - cfg_len=8, send 7 bits then stop -> err_len one pulse, fifo_level stays 0.
  - Send 9 bits -> err_len at the 9th strobe.
  - Send 3 bits then idle for 70 cycles -> err_len at timeout, busy drops.
- Glitch: a 3-cycle low pulse on sl1_i -> err_level at the strobe, state returns to IDLE, the next valid word 0x5A is received correctly.
- Overflow: m_ready=0, FIFO_DEPTH=4. Send 5 words 0x01..0x05 -> fifo_level=4, ovf=1. Drain to get 0x01..0x04 in order. Then pulse ovf_clr -> ovf=0.
- Full width: cfg_len=0 with DATA_W=32. Send 0xDEADBEEF -> m_data=0xDEADBEEF. Assert rst_n low mid-word -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/sl_rx_fifo.sv
// Two-wire return-to-idle serial-line receiver with a first-word-fall-through receive FIFO.
// Words are framed by low pulses on sl0/sl1 and terminated by both lines low (stop).
module sl_rx_fifo #(
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int STROBE_POS  = 8,
  parameter int TIMEOUT     = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sl0_i,
  input  logic                          sl1_i,
  input  logic                          cfg_en,
  input  logic [5:0]                    cfg_len,
  input  logic                          cfg_parity_en,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_W-1:0]             m_data,
  output logic                          m_perr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          err_len,
  output logic                          err_level,
  output logic                          ovf,
  input  logic                          ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_POS - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT - 1);
  localparam logic [6:0]    DW7         = 7'(DATA_W);
  localparam logic [AW:0]   LVL_FULL    = (AW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_STROBE  = 3'd1;
  localparam logic [2:0] ST_RELEASE = 3'd2;
  localparam logic [2:0] ST_GAP     = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;

  // Odd parity: error when data ones plus the parity bit come to an even count.
  function automatic logic parity_err(input logic [DATA_W-1:0] data, input logic pbit,
                                      input logic en);
    parity_err = en & ~((^data) ^ pbit);
  endfunction

  logic [SYNC_STAGES-1:0] r_sync0, r_sync1;
  logic                   w_s0, w_s1;
  logic [2:0]             r_state;
  logic [CW-1:0]          r_cnt;
  logic [6:0]             r_bit_cnt;
  logic [5:0]             r_len;
  logic                   r_par;
  logic [DATA_W-1:0]      r_shift;
  logic                   r_pbit;
  logic                   r_push;
  logic [DATA_W-1:0]      r_push_data;
  logic                   r_push_perr;
  logic                   r_err_len, r_err_level;
  logic [5:0]             w_len_map;
  logic [6:0]             w_total;

  logic [DATA_W:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [AW:0]            r_level;
  logic                   r_ovf;
  logic                   w_pop, w_full, w_push, w_ovf_evt;

  assign w_s0      = r_sync0[SYNC_STAGES-1];
  assign w_s1      = r_sync1[SYNC_STAGES-1];
  assign w_len_map = ((cfg_len == 6'd0) || ({1'b0, cfg_len} > DW7)) ? DW7[5:0] : cfg_len;
  assign w_total   = {1'b0, r_len} + {6'd0, r_par};

  // Input synchronisers, idle-high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync0 <= '1;
      r_sync1 <= '1;
    end else begin
      r_sync0 <= {r_sync0[SYNC_STAGES-2:0], sl0_i};
      r_sync1 <= {r_sync1[SYNC_STAGES-2:0], sl1_i};
    end
  end

  // Receive FSM: strobe, release, gap and drain phases of each bit and word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit_cnt   <= 7'd0;
      r_len       <= 6'd0;
      r_par       <= 1'b0;
      r_shift     <= '0;
      r_pbit      <= 1'b0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_push_perr <= 1'b0;
      r_err_len   <= 1'b0;
      r_err_level <= 1'b0;
    end else begin
      r_push      <= 1'b0;
      r_err_len   <= 1'b0;
      r_err_level <= 1'b0;
      if (!cfg_en) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (!w_s0 || !w_s1) begin
              r_len     <= w_len_map;
              r_par     <= cfg_parity_en;
              r_cnt     <= '0;
              r_bit_cnt <= 7'd0;
              r_shift   <= '0;
              r_pbit    <= 1'b0;
              r_state   <= ST_STROBE;
            end
          end
          ST_STROBE: begin
            if (r_cnt == STROBE_LAST) begin
              r_cnt <= '0;
              if (w_s0 && w_s1) begin
                r_err_level <= 1'b1;
                r_state     <= ST_IDLE;
              end else if (w_s0 ^ w_s1) begin
                if (r_bit_cnt < w_total) begin
                  // w_s0 high means sl1 was the low wire, i.e. a '1'.
                  if (r_bit_cnt < {1'b0, r_len}) begin
                    r_shift <= r_shift | ({{(DATA_W-1){1'b0}}, w_s0} << r_bit_cnt);
                  end else begin
                    r_pbit <= w_s0;
                  end
                  r_bit_cnt <= r_bit_cnt + 7'd1;
                  r_state   <= ST_RELEASE;
                end else begin
                  r_err_len <= 1'b1;
                  r_state   <= ST_DRAIN;
                end
              end else begin
                r_state <= ST_DRAIN;
                if (r_bit_cnt == w_total) begin
                  r_push      <= 1'b1;
                  r_push_data <= r_shift;
                  r_push_perr <= parity_err(r_shift, r_pbit, r_par);
                end else begin
                  r_err_len <= 1'b1;
                end
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_RELEASE: begin
            if (w_s0 && w_s1) begin
              r_cnt   <= '0;
              r_state <= ST_GAP;
            end else if (r_cnt == TO_LAST) begin
              r_cnt       <= '0;
              r_err_level <= 1'b1;
              r_state     <= ST_DRAIN;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_GAP: begin
            if (!w_s0 || !w_s1) begin
              r_cnt   <= '0;
              r_state <= ST_STROBE;
            end else if (r_cnt == TO_LAST) begin
              r_cnt     <= '0;
              r_err_len <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_DRAIN: begin
            if (w_s0 && w_s1) begin
              r_state <= ST_IDLE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign w_pop     = (r_level != '0) && m_ready;
  assign w_full    = (r_level == LVL_FULL);
  assign w_push    = r_push && (!w_full || w_pop);
  assign w_ovf_evt = r_push && w_full && !w_pop;

  // Receive FIFO storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {r_push_perr, r_push_data};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end else begin
        r_ovf <= r_ovf;
      end
    end
  end

  assign m_valid    = (r_level != '0);
  assign m_data     = r_mem[r_rd_ptr][DATA_W-1:0];
  assign m_perr     = r_mem[r_rd_ptr][DATA_W];
  assign fifo_level = r_level;
  assign busy       = (r_state != ST_IDLE);
  assign err_len    = r_err_len;
  assign err_level  = r_err_level;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_sl_rx_fifo.sv
// Scoreboard bench for sl_rx_fifo: stimulus queues expected words from a word-level model,
// a negedge monitor pops and compares whatever the FIFO hands out and counts error pulses.
module tb_sl_rx_fifo;

  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sl0_i = 1'b1, sl1_i = 1'b1;
  logic        cfg_en = 1'b0;
  logic [5:0]  cfg_len = 6'd8;
  logic        cfg_parity_en = 1'b0;
  logic        m_valid, m_ready = 1'b0;
  logic [31:0] m_data;
  logic        m_perr;
  logic [2:0]  fifo_level;
  logic        busy, err_len, err_level, ovf;
  logic        ovf_clr = 1'b0;

  int n_tests = 0, n_fail = 0;
  int got_err_len = 0, got_err_level = 0;
  int exp_err_len = 0, exp_err_level = 0;
  logic exp_ovf = 1'b0;
  logic [32:0] sb[$];
  int lo_min = 12, lo_max = 24, hi_min = 3, hi_max = 30;

  always #5 clk = ~clk;

  sl_rx_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .STROBE_POS(8), .TIMEOUT(64),
               .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sl0_i(sl0_i), .sl1_i(sl1_i), .cfg_en(cfg_en),
    .cfg_len(cfg_len), .cfg_parity_en(cfg_parity_en), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_perr(m_perr), .fifo_level(fifo_level), .busy(busy),
    .err_len(err_len), .err_level(err_level), .ovf(ovf), .ovf_clr(ovf_clr));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: count error pulses and compare every word the consumer accepts.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n) begin
      if (err_len)   got_err_len++;
      if (err_level) got_err_level++;
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pop: got %0h, expected no word", m_data);
        end else begin
          e = sb.pop_front();
          check("pop_data", m_data, e[31:0]);
          check("pop_perr", 32'(m_perr), 32'(e[32]));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    if (b) sl1_i = 1'b0;
    else   sl0_i = 1'b0;
    cyc($urandom_range(lo_max, lo_min));
    sl0_i = 1'b1;
    sl1_i = 1'b1;
    cyc($urandom_range(hi_max, hi_min));
  endtask

  task automatic send_stop();
    sl0_i = 1'b0;
    sl1_i = 1'b0;
    cyc(20);
    sl0_i = 1'b1;
    sl1_i = 1'b1;
    cyc(20);
  endtask

  // nbits < 0 sends exactly the configured count; stop=0 leaves the line idle afterwards.
  task automatic send_word(input logic [5:0] lcfg, input logic par, input logic [31:0] data,
                           input logic pbit, input int nbits, input bit stop);
    int L, total, n, ones;
    logic [31:0] mask, md;
    logic b, perr;
    cfg_len = lcfg;
    cfg_parity_en = par;
    L = (lcfg == 6'd0 || lcfg > 6'd32) ? 32 : int'(lcfg);
    total = L + (par ? 1 : 0);
    n = (nbits < 0) ? total : nbits;
    for (int i = 0; i < n; i++) begin
      if (i < L) b = data[i];
      else if (i == L) b = pbit;
      else b = 1'b1;
      send_bit(b);
    end
    if (!stop) begin
      exp_err_len++;
      cyc(80);
    end else if (n != total) begin
      exp_err_len++;
      send_stop();
    end else begin
      mask = (L == 32) ? 32'hFFFF_FFFF : ((32'h1 << L) - 32'h1);
      md = data & mask;
      ones = $countones(md) + (pbit ? 1 : 0);
      perr = par && ((ones % 2) == 0);
      if (!m_ready && sb.size() == FIFO_DEPTH) exp_ovf = 1'b1;
      else sb.push_back({perr, md});
      send_stop();
    end
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      cyc(1);
      t++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: %0d words still expected, wanted 0", name, sb.size());
    end
  endtask

  task automatic check_errs(input string name);
    check({name, "_err_len"}, 32'(got_err_len), 32'(exp_err_len));
    check({name, "_err_level"}, 32'(got_err_level), 32'(exp_err_level));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] lc;
    int sel;
    rst_n = 1'b0;
    cyc(3);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_busy_ovf_err", {28'd0, busy, ovf, err_len, err_level}, 32'd0);
    rst_n = 1'b1;
    cfg_en = 1'b1;
    cyc(3);

    // Basic word, fixed 20/20 pulses
    lo_min = 20; lo_max = 20; hi_min = 20; hi_max = 20;
    send_word(6'd8, 1'b0, 32'hA5, 1'b0, -1, 1'b1);
    check("basic_valid", 32'(m_valid), 32'd1);
    check("basic_level", 32'(fifo_level), 32'd1);
    m_ready = 1'b1;
    wait_drain("basic_drain");
    check_errs("basic");
    lo_min = 12; lo_max = 24; hi_min = 3; hi_max = 30;

    // Parity good and bad
    send_word(6'd8, 1'b1, 32'h03, 1'b1, -1, 1'b1);
    send_word(6'd8, 1'b1, 32'h03, 1'b0, -1, 1'b1);
    wait_drain("parity_drain");

    // Length errors: short, overlength, gap timeout
    send_word(6'd8, 1'b0, 32'h7F, 1'b0, 7, 1'b1);
    check("short_level", 32'(fifo_level), 32'd0);
    send_word(6'd8, 1'b0, 32'h1FF, 1'b0, 9, 1'b0);
    send_word(6'd8, 1'b0, 32'h5, 1'b0, 3, 1'b0);
    check("timeout_busy", 32'(busy), 32'd0);
    check_errs("len");

    // Glitch, then a good word
    sl1_i = 1'b0; cyc(3); sl1_i = 1'b1; cyc(30);
    exp_err_level++;
    check("glitch_busy", 32'(busy), 32'd0);
    send_word(6'd8, 1'b0, 32'h5A, 1'b0, -1, 1'b1);
    wait_drain("glitch_drain");

    // Line stuck low past the release timeout
    sl0_i = 1'b0; cyc(100); sl0_i = 1'b1; cyc(20);
    exp_err_level++;
    check_errs("level");

    // Disable mid-word: silently discarded
    cfg_len = 6'd8;
    cfg_parity_en = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    cfg_en = 1'b0;
    cyc(2);
    check("disable_busy", 32'(busy), 32'd0);
    cfg_en = 1'b1;
    cyc(5);
    check_errs("disable");

    // Overflow with consumer stalled
    m_ready = 1'b0;
    for (int w = 1; w <= 5; w++) send_word(6'd8, 1'b0, 32'(w), 1'b0, -1, 1'b1);
    check("ovf_level", 32'(fifo_level), 32'd4);
    check("ovf_set", 32'(ovf), 32'(exp_ovf));
    m_ready = 1'b1;
    wait_drain("ovf_drain");
    cyc(2);
    check("ovf_kept", 32'(ovf), 32'd1);
    ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    check("ovf_clr", 32'(ovf), 32'(exp_ovf));

    // Randomised words, consumer always ready
    for (int k = 0; k < 18; k++) begin
      sel = $urandom_range(9, 0);
      lc = (sel == 0) ? 6'd0 : (sel == 1) ? 6'($urandom_range(63, 33)) : 6'($urandom_range(32, 1));
      if (sel == 9)
        send_word(lc, 1'($urandom), $urandom, 1'($urandom), $urandom_range(4, 1), 1'b1);
      else
        send_word(lc, 1'($urandom), $urandom, 1'($urandom), -1, 1'b1);
    end
    wait_drain("rand_drain");
    check_errs("rand");

    // Full width, then reset mid-word
    m_ready = 1'b0;
    send_word(6'd0, 1'b0, 32'hDEAD_BEEF, 1'b0, -1, 1'b1);
    check("full_width", m_data, sb[0][31:0]);
    check("full_level", 32'(fifo_level), 32'd1);
    sl1_i = 1'b0; cyc(5);
    check("midword_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    cyc(1);
    sb.delete();
    check("rst_mid_valid_level", {28'd0, m_valid, fifo_level}, 32'd0);
    check("rst_mid_data", m_data, 32'd0);
    check("rst_mid_flags", {28'd0, busy, ovf, err_len, err_level}, 32'd0);
    sl1_i = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    m_ready = 1'b1;
    cyc(30);
    check_errs("final");
    check("final_level", 32'(fifo_level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
